stepdown_deadtime_sequencer: RTL and testbench

Digital gate-drive sequencer for the step-down control loop. It takes the loop PWM request and drives separate high-side and low-side enables. The fixed analog delay cells are replaced by programmable dead-time and minimum-on-time intervals counted in clock cycles. It guarantees break-before-make on every transition, flags aborted transitions, and sits between the loop PWM comparator and the gate drivers.

---
 rtl/stepdown_deadtime_sequencer_if.sv | 14 +
 rtl/stepdown_deadtime_sequencer.sv | 76 +++++++
 tb/tb_stepdown_deadtime_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/stepdown_deadtime_sequencer_if.sv
// stepdown_deadtime_sequencer_if: request/config in, gate enables and status out
interface stepdown_deadtime_sequencer_if #(parameter int CW = 6);
  logic en;
  logic i;
  logic [CW-1:0] dt_lh;
  logic [CW-1:0] dt_hl;
  logic [CW-1:0] blank;
  logic hs_o;
  logic ls_o;
  logic busy;
  logic glitch;
  modport master (output en, i, dt_lh, dt_hl, blank, input hs_o, ls_o, busy, glitch);
  modport slave (input en, i, dt_lh, dt_hl, blank, output hs_o, ls_o, busy, glitch);
endinterface

// File: rtl/stepdown_deadtime_sequencer.sv
// stepdown_deadtime_sequencer: break-before-make gate sequencer with programmable dead time and blanking
module stepdown_deadtime_sequencer #(parameter int CW = 6) (
  input logic CELCLK,
  input logic CELRSTN,
  input logic CELV,
  input logic CELG,
  input logic CELSUB,
  stepdown_deadtime_sequencer_if.slave bus
);
  typedef enum logic [2:0] {OFF, LS, DT_LH, HS, DT_HL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_dec, lh_load, hl_load;
  logic cnt_z, i_q, en_q, hs_q, ls_q, busy_q, glitch_q, glitch_d;
  logic unused_supply;
  assign unused_supply = CELV ^ CELG ^ CELSUB;
  assign cnt_z = cnt_q == '0;
  assign cnt_dec = cnt_z ? '0 : cnt_q - CW'(1);
  // a zero dead time still yields one both-off cycle
  assign lh_load = (bus.dt_lh == '0) ? '0 : bus.dt_lh - CW'(1);
  assign hl_load = (bus.dt_hl == '0) ? '0 : bus.dt_hl - CW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_dec;
    glitch_d = 1'b0;
    if (!en_q) begin
      state_d = OFF;
      cnt_d = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = i_q ? DT_LH : LS;
          cnt_d = i_q ? lh_load : bus.blank;
        end
        LS: if (cnt_z && i_q) begin
          state_d = DT_LH;
          cnt_d = lh_load;
        end
        HS: if (cnt_z && !i_q) begin
          state_d = DT_HL;
          cnt_d = hl_load;
        end
        DT_LH, DT_HL: if (cnt_z) begin
          state_d = i_q ? HS : LS;
          cnt_d = bus.blank;
          glitch_d = (state_q == DT_LH) != i_q;
        end
        default: state_d = OFF;
      endcase
    end
  end
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state_q <= OFF;
      cnt_q <= '0;
      i_q <= 1'b0;
      en_q <= 1'b0;
      hs_q <= 1'b0;
      ls_q <= 1'b0;
      busy_q <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      i_q <= bus.i;
      en_q <= bus.en;
      hs_q <= state_d == HS;
      ls_q <= state_d == LS;
      busy_q <= (state_d == DT_LH) || (state_d == DT_HL);
      glitch_q <= glitch_d;
    end
  end
  assign bus.hs_o = hs_q;
  assign bus.ls_o = ls_q;
  assign bus.busy = busy_q;
  assign bus.glitch = glitch_q;
endmodule

// File: tb/tb_stepdown_deadtime_sequencer.sv
// tb_stepdown_deadtime_sequencer: directed scenarios with hand-computed {hs_o,ls_o,busy,glitch}
module tb_stepdown_deadtime_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [3:0] o;
  stepdown_deadtime_sequencer_if #(.CW(6)) bus ();
  stepdown_deadtime_sequencer #(.CW(6)) dut (
    .CELCLK(clk), .CELRSTN(rst_n), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0), .bus(bus)
  );
  always #5 clk = ~clk;
  assign o = {bus.hs_o, bus.ls_o, bus.busy, bus.glitch};
  always @(negedge clk) begin
    compared++;
    if (bus.hs_o === 1'b1 && bus.ls_o === 1'b1) begin
      mismatched++;
      $display("FAIL overlap t=%0t hs_o=%b ls_o=%b required not both 1", $time, bus.hs_o, bus.ls_o);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.en = 1'b1; bus.i = 1'b1; bus.dt_lh = 6'd3; bus.dt_hl = 6'd2; bus.blank = 6'd0;
    #1 rst_n = 1'b0;
    #1 compared++;
    if (o !== 4'b0000) begin mismatched++; $display("FAIL reset_async hs/ls/busy/glitch=%b required 0000", o); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick(); compared++;
    if (o !== 4'b0000) begin mismatched++; $display("FAIL reset_off_cycle got %b required 0000", o); end
    for (int k = 0; k < 3; k++) begin
      tick(); compared++;
      if (o !== 4'b0010) begin mismatched++; $display("FAIL reset_dt_lh step %0d got %b required 0010", k, o); end
    end
    tick(); compared++;
    if (o !== 4'b1000) begin mismatched++; $display("FAIL reset_hs_on got %b required 1000", o); end
  endtask
  task automatic test_basic();
    logic [3:0] exp_fall [4] = '{4'b1000, 4'b0010, 4'b0010, 4'b0100};
    logic [3:0] exp_rise [5] = '{4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
    bus.i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); compared++;
      if (o !== exp_fall[k]) begin mismatched++; $display("FAIL basic_hl step %0d got %b required %b", k, o, exp_fall[k]); end
    end
    bus.i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); compared++;
      if (o !== exp_rise[k]) begin mismatched++; $display("FAIL basic_lh step %0d got %b required %b", k, o, exp_rise[k]); end
    end
  endtask
  task automatic test_zero_dt();
    logic [3:0] exp_z [3] = '{4'b0100, 4'b0010, 4'b1000};
    bus.i = 1'b0;
    repeat (4) tick();
    compared++;
    if (o !== 4'b0100) begin mismatched++; $display("FAIL zero_dt_setup got %b required 0100", o); end
    bus.dt_lh = 6'd0; bus.i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); compared++;
      if (o !== exp_z[k]) begin mismatched++; $display("FAIL zero_dt step %0d got %b required %b", k, o, exp_z[k]); end
    end
  endtask
  task automatic test_blank();
    logic [3:0] exp_in [4] = '{4'b0100, 4'b0010, 4'b0010, 4'b1000};
    logic [3:0] exp_p [4] = '{4'b0010, 4'b0010, 4'b1001, 4'b1000};
    bus.dt_hl = 6'd2; bus.dt_lh = 6'd2; bus.i = 1'b0;
    repeat (4) tick();
    compared++;
    if (o !== 4'b0100) begin mismatched++; $display("FAIL blank_setup got %b required 0100", o); end
    bus.blank = 6'd8; bus.i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); compared++;
      if (o !== exp_in[k]) begin mismatched++; $display("FAIL blank_entry step %0d got %b required %b", k, o, exp_in[k]); end
    end
    bus.i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) bus.i = 1'b1;
      tick(); compared++;
      if (o !== 4'b1000) begin mismatched++; $display("FAIL blank_hold step %0d got %b required 1000", k, o); end
    end
    bus.i = 1'b0;
    tick();
    bus.i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); compared++;
      if (o !== exp_p[k]) begin mismatched++; $display("FAIL blank_short_pulse step %0d got %b required %b", k, o, exp_p[k]); end
    end
  endtask
  task automatic test_abort();
    bus.blank = 6'd0; bus.i = 1'b0;
    repeat (12) tick();
    compared++;
    if (o !== 4'b0100) begin mismatched++; $display("FAIL abort_setup got %b required 0100", o); end
    bus.dt_lh = 6'd5; bus.i = 1'b1;
    tick(); compared++;
    if (o !== 4'b0100) begin mismatched++; $display("FAIL abort_latency got %b required 0100", o); end
    tick(); compared++;
    if (o !== 4'b0010) begin mismatched++; $display("FAIL abort_dt_entry got %b required 0010", o); end
    bus.i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); compared++;
      if (o !== 4'b0010) begin mismatched++; $display("FAIL abort_dt step %0d got %b required 0010", k, o); end
    end
    tick(); compared++;
    if (o !== 4'b0101) begin mismatched++; $display("FAIL abort_glitch got %b required 0101", o); end
    tick(); compared++;
    if (o !== 4'b0100) begin mismatched++; $display("FAIL abort_glitch_clear got %b required 0100", o); end
  endtask
  task automatic test_disable();
    logic [3:0] exp_d [7] = '{4'b0100, 4'b0010, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0010};
    bus.dt_lh = 6'd1; bus.i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) bus.en = 1'b0;
      if (k == 5) bus.en = 1'b1;
      tick(); compared++;
      if (o !== exp_d[k]) begin mismatched++; $display("FAIL disable step %0d got %b required %b", k, o, exp_d[k]); end
    end
    tick(); compared++;
    if (o !== 4'b1000) begin mismatched++; $display("FAIL disable_resume got %b required 1000", o); end
  endtask
  task automatic test_rst_mid();
    logic [3:0] exp_r [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b1000};
    bus.dt_hl = 6'd4; bus.i = 1'b0;
    tick();
    tick(); compared++;
    if (o !== 4'b0010) begin mismatched++; $display("FAIL rst_mid_setup got %b required 0010", o); end
    tick();
    #2 rst_n = 1'b0;
    #1 compared++;
    if (o !== 4'b0000) begin mismatched++; $display("FAIL rst_mid_clear got %b required 0000", o); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin bus.dt_lh = 6'd2; bus.i = 1'b1; end
      tick(); compared++;
      if (o !== exp_r[k]) begin mismatched++; $display("FAIL rst_mid_restart step %0d got %b required %b", k, o, exp_r[k]); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_zero_dt();
    test_blank();
    test_abort();
    test_disable();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
